// File: rtl/pixel_point_op.sv
// Framebuffer point-operation engine: one pass over NPIX pixels, read-modify-write
// of each RGB pixel with invert, saturating brighten/darken or threshold.
module pixel_point_op #(
    parameter int CW     = 4,
    parameter int ADDR_W = 18,
    parameter int NPIX   = 120000,
    parameter int RD_LAT = 1
) (
    input  logic              clk_40,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [CW-1:0]     step,
    input  logic [CW-1:0]     thr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CW-1:0]     rd_r,
    input  logic [CW-1:0]     rd_g,
    input  logic [CW-1:0]     rd_b,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CW-1:0]     wr_r,
    output logic [CW-1:0]     wr_g,
    output logic [CW-1:0]     wr_b,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        op_q;
    logic [CW-1:0]     step_q;
    logic [CW-1:0]     thr_q;
    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] addr_pipe_q [RD_LAT];
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [CW-1:0]     wr_r_q, wr_g_q, wr_b_q;
    logic              accept_s;
    logic              issue_s;
    logic              pipe_empty_s;

    function automatic logic [CW-1:0] point_op(
        input logic [1:0]    mode,
        input logic [CW-1:0] px,
        input logic [CW-1:0] amt,
        input logic [CW-1:0] lvl
    );
        logic [CW:0]   sum;
        logic [CW-1:0] res;
        sum = {1'b0, px} + {1'b0, amt};
        case (mode)
            2'b00:   res = ~px;
            2'b01:   res = sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
            2'b10:   res = (px < amt) ? {CW{1'b0}} : (px - amt);
            2'b11:   res = (px >= lvl) ? {CW{1'b1}} : {CW{1'b0}};
            default: res = ~px;
        endcase
        return res;
    endfunction

    // The start cycle itself issues the read of address 0, so RUN begins at address 1.
    assign accept_s     = (state_q == S_IDLE) && start;
    assign issue_s      = accept_s || (state_q == S_RUN);
    assign pipe_empty_s = (vld_q == {RD_LAT{1'b0}}) && (wr_en_q == 1'b0);

    // Sweep sequencer next-state logic.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d   = S_RUN;
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end else begin
                    rd_addr_d = {ADDR_W{1'b0}};
                end
            end
            S_RUN: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (pipe_empty_s) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_FIN: begin
                state_d   = S_IDLE;
                rd_addr_d = {ADDR_W{1'b0}};
            end
            default: begin
                state_d   = S_IDLE;
                rd_addr_d = {ADDR_W{1'b0}};
                busy_d    = 1'b0;
            end
        endcase
    end

    // Sequencer state and per-pass operation settings.
    always_ff @(posedge clk_40 or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_addr_q <= {ADDR_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            op_q      <= 2'b00;
            step_q    <= {CW{1'b0}};
            thr_q     <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (accept_s) begin
                op_q   <= op;
                step_q <= step;
                thr_q  <= thr;
            end
        end
    end

    // Outstanding-read tracker: address travels alongside the BRAM latency.
    always_ff @(posedge clk_40 or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                vld_q[k]       <= 1'b0;
                addr_pipe_q[k] <= {ADDR_W{1'b0}};
            end
        end else begin
            vld_q[0]       <= issue_s;
            addr_pipe_q[0] <= rd_addr_q;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k]       <= vld_q[k-1];
                addr_pipe_q[k] <= addr_pipe_q[k-1];
            end
        end
    end

    // Result register; pixel outputs hold between writes.
    always_ff @(posedge clk_40 or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_r_q    <= {CW{1'b0}};
            wr_g_q    <= {CW{1'b0}};
            wr_b_q    <= {CW{1'b0}};
        end else begin
            wr_en_q <= vld_q[RD_LAT-1];
            if (vld_q[RD_LAT-1]) begin
                wr_addr_q <= addr_pipe_q[RD_LAT-1];
                wr_r_q    <= point_op(op_q, rd_r, step_q, thr_q);
                wr_g_q    <= point_op(op_q, rd_g, step_q, thr_q);
                wr_b_q    <= point_op(op_q, rd_b, step_q, thr_q);
            end
        end
    end

    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_r    = wr_r_q;
    assign wr_g    = wr_g_q;
    assign wr_b    = wr_b_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pixel_point_op.sv
// Scoreboard bench for pixel_point_op: two instances (read latency 1 and 3) share
// stimulus; expected writes and per-cycle status come from a behavioural model.
module tb_pixel_point_op;

    localparam int CW   = 4;
    localparam int AW   = 18;
    localparam int NPIX = 8;

    typedef struct {
        int          cyc;
        int          addr;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  step;
    logic [3:0]  thr;

    logic [AW-1:0] rd_addr_s [2];
    logic          wr_en_s   [2];
    logic [AW-1:0] wr_addr_s [2];
    logic [3:0]    wr_r_s    [2];
    logic [3:0]    wr_g_s    [2];
    logic [3:0]    wr_b_s    [2];
    logic          busy_s    [2];
    logic          done_s    [2];

    logic [11:0] mem [NPIX];
    logic [11:0] rp1 [1];
    logic [11:0] rp3 [3];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   s_cyc = 0;
    bit   active = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pixel_point_op #(.CW(CW), .ADDR_W(AW), .NPIX(NPIX), .RD_LAT(1)) u_dut_l1 (
        .clk_40(clk), .rst(rst), .start(start), .op(op), .step(step), .thr(thr),
        .rd_addr(rd_addr_s[0]), .rd_r(rp1[0][11:8]), .rd_g(rp1[0][7:4]), .rd_b(rp1[0][3:0]),
        .wr_en(wr_en_s[0]), .wr_addr(wr_addr_s[0]), .wr_r(wr_r_s[0]), .wr_g(wr_g_s[0]),
        .wr_b(wr_b_s[0]), .busy(busy_s[0]), .done(done_s[0])
    );

    pixel_point_op #(.CW(CW), .ADDR_W(AW), .NPIX(NPIX), .RD_LAT(3)) u_dut_l3 (
        .clk_40(clk), .rst(rst), .start(start), .op(op), .step(step), .thr(thr),
        .rd_addr(rd_addr_s[1]), .rd_r(rp3[2][11:8]), .rd_g(rp3[2][7:4]), .rd_b(rp3[2][3:0]),
        .wr_en(wr_en_s[1]), .wr_addr(wr_addr_s[1]), .wr_r(wr_r_s[1]), .wr_g(wr_g_s[1]),
        .wr_b(wr_b_s[1]), .busy(busy_s[1]), .done(done_s[1])
    );

    // Framebuffer read ports with latency 1 and 3, plus the cycle counter.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rp1[0] <= mem[rd_addr_s[0][2:0]];
        rp3[0] <= mem[rd_addr_s[1][2:0]];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_px(input int o, input int st, input int th,
                                           input logic [11:0] px);
        logic [11:0] res;
        int v;
        int w;
        res = 12'h000;
        for (int c = 0; c < 3; c++) begin
            v = int'(px[c*4 +: 4]);
            case (o)
                0:       w = 15 - v;
                1:       w = (v + st > 15) ? 15 : v + st;
                2:       w = (v < st) ? 0 : v - st;
                default: w = (v >= th) ? 15 : 0;
            endcase
            res[c*4 +: 4] = w[3:0];
        end
        return res;
    endfunction

    // Monitor: per-cycle status against the pass timeline, writes against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int   lat;
                int   k;
                bit   inpass;
                bit   has;
                exp_t e;
                lat    = (i == 0) ? 1 : 3;
                k      = cyc - s_cyc;
                inpass = active && (k <= NPIX + lat + 2);
                chk($sformatf("busy_L%0d", lat), int'(busy_s[i]),
                    int'(inpass && k >= 1 && k <= NPIX + lat + 1));
                chk($sformatf("done_L%0d", lat), int'(done_s[i]),
                    int'(inpass && k == NPIX + lat + 2));
                if (!inpass)
                    chk($sformatf("rd_addr_idle_L%0d", lat), int'(rd_addr_s[i]), 0);
                else if (k <= NPIX + lat + 1)
                    chk($sformatf("rd_addr_L%0d", lat), int'(rd_addr_s[i]),
                        (k < NPIX) ? k : NPIX - 1);
                has = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (has) e = (i == 0) ? q0[0] : q1[0];
                if (wr_en_s[i]) begin
                    if (!has) begin
                        chk($sformatf("unexpected_write_L%0d", lat), int'(wr_addr_s[i]), -1);
                    end else begin
                        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                        chk($sformatf("wr_addr_L%0d", lat), int'(wr_addr_s[i]), e.addr);
                        chk($sformatf("wr_rgb_L%0d", lat),
                            int'({wr_r_s[i], wr_g_s[i], wr_b_s[i]}), int'(e.rgb));
                        chk($sformatf("wr_cycle_L%0d", lat), k, e.cyc - s_cyc);
                    end
                end else if (has && e.cyc <= cyc) begin
                    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    chk($sformatf("missing_write_L%0d", lat), -1, e.addr);
                end
            end
        end
    end

    // One pass; call at posedge+1. Negative offsets disable stray start / thr change / reset.
    task automatic run_pass(input logic [1:0] o, input logic [3:0] st, input logic [3:0] th,
                            input int stray, input int thr_chg, input int rst_at);
        exp_t e;
        op     = o;
        step   = st;
        thr    = th;
        start  = 1'b1;
        s_cyc  = cyc;
        active = 1'b1;
        for (int a = 0; a < NPIX; a++) begin
            e.addr = a;
            e.rgb  = ref_px(int'(o), int'(st), int'(th), mem[a]);
            e.cyc  = s_cyc + a + 2;
            q0.push_back(e);
            e.cyc  = s_cyc + a + 4;
            q1.push_back(e);
        end
        for (int k = 1; k < NPIX + 13; k++) begin
            @(posedge clk);
            #1;
            start = (k == stray) ? 1'b1 : 1'b0;
            if (k == thr_chg) thr = 4'd0;
            if (k == rst_at) begin
                rst    = 1'b1;
                active = 1'b0;
                q0.delete();
                q1.delete();
            end
            if (rst_at >= 0 && k == rst_at + 2) rst = 1'b0;
        end
        chk("pending_writes_L1", q0.size(), 0);
        chk("pending_writes_L3", q1.size(), 0);
    endtask

    task automatic fill_random();
        for (int a = 0; a < NPIX; a++) mem[a] = 12'($urandom_range(0, 4095));
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < NPIX; a++) mem[a] = {a[3:0], a[3:0], a[3:0]};
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        step  = 4'd0;
        thr   = 4'd0;
        fill_ramp();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_wr_addr", int'(wr_addr_s[i]), 0);
            chk("reset_wr_rgb", int'({wr_r_s[i], wr_g_s[i], wr_b_s[i]}), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        fill_ramp();
        run_pass(2'b00, 4'd0, 4'd0, -1, -1, -1);
        fill_random();
        mem[0] = 12'hCA3;
        run_pass(2'b01, 4'd5, 4'd0, -1, -1, -1);
        fill_random();
        run_pass(2'b01, 4'd0, 4'd0, -1, -1, -1);
        fill_random();
        mem[0] = 12'h249;
        run_pass(2'b10, 4'd4, 4'd0, -1, -1, -1);
        fill_random();
        mem[0] = 12'h777;
        mem[1] = 12'h888;
        mem[2] = 12'hFFF;
        run_pass(2'b11, 4'd0, 4'd8, 3, 2, -1);
        fill_ramp();
        run_pass(2'b00, 4'd0, 4'd0, -1, -1, 5);
        run_pass(2'b00, 4'd0, 4'd0, -1, -1, -1);
        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_pass(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), -1, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
